fir_decoder: RTL and testbench

FIR_DECODER -- requirements
Module: fir_decoder

---
 rtl/fir_decoder.sv | 114 +++++++++++
 tb/tb_fir_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decoder.sv
// Inverse of a 3-tap FIR encoder: recovers 4-bit samples x[n] from the filtered stream y[n],
// flagging any sample that no 4-bit x[n] could have produced given the recovered history.
module fir_decoder #(
   parameter int C0          = 3,
   parameter int C1          = 4,
   parameter int C2          = 5,
   parameter int HALT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       halt,
   input  logic [8:0] in,
   output logic [3:0] out,
   output logic       valid,
   output logic       err,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_e;

   localparam int CW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

   state_e          state_q, state_d;
   logic   [3:0]    h1_q, h1_d;
   logic   [3:0]    h2_q, h2_d;
   logic   [3:0]    out_q, out_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic   [CW-1:0] cnt_q, cnt_d;

   int              resid;
   logic            legal;
   logic   [3:0]    x;

   // Full 32-bit signed arithmetic, so a negative residual never wraps into a legal value.
   always_comb begin
      resid = int'(in) - C1 * int'(h1_q) - C2 * int'(h2_q);
      legal = (resid >= 0) && (resid <= C0 * 15) && ((resid % C0) == 0);
      x     = legal ? 4'(resid / C0) : 4'd0;
   end

   // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      h1_d    = h1_q;
      h2_d    = h2_q;
      out_d   = out_q;
      valid_d = 1'b0;
      err_d   = err_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               h1_d    = '0;
               h2_d    = '0;
               err_d   = 1'b0;
            end
         end
         RUN: begin
            if (halt) begin
               cnt_d   = '0;
               state_d = (HALT_CYCLES == 0) ? DONE : FLUSH;
            end else begin
               out_d   = x;
               valid_d = 1'b1;
               h2_d    = h1_q;
               h1_d    = x;
               if (!legal) err_d = 1'b1;
            end
         end
         FLUSH: begin
            if (cnt_q == CW'(HALT_CYCLES - 1)) state_d = DONE;
            else                                cnt_d   = cnt_q + CW'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         h1_q    <= '0;
         h2_q    <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         h1_q    <= h1_d;
         h2_q    <= h2_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign err   = err_q;
   assign done  = (state_q == DONE);

endmodule

// File: tb/tb_fir_decoder.sv
// Scoreboarded bench for fir_decoder: directed scenarios plus randomized runs built by
// forward-encoding random samples, with occasional arbitrary inputs decoded by exhaustive search.
module tb_fir_decoder;

   localparam int C0 = 3;
   localparam int C1 = 4;
   localparam int C2 = 5;
   localparam int HC = 2;

   logic       clk;
   logic       rst;
   logic       start;
   logic       halt;
   logic [8:0] din;
   logic [3:0] dout;
   logic       valid;
   logic       err;
   logic       done;

   fir_decoder #(.C0(C0), .C1(C1), .C2(C2), .HALT_CYCLES(HC)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .halt (halt),
      .in   (din),
      .out  (dout),
      .valid(valid),
      .err  (err),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int out;
      int err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference state: the last two recovered samples, sticky error, last presented output.
   int   m_h1, m_h2, m_err, m_last_out;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid output must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid=1 out=%0d, expected no output", dout);
         end else begin
            e = sb_q.pop_front();
            check("sb_out", int'(dout), e.out);
            check("sb_err", int'(err), e.err);
            check("sb_done_low", int'(done), 0);
         end
      end
   end

   task automatic model_clear();
      m_h1  = 0;
      m_h2  = 0;
      m_err = 0;
   endtask

   task automatic model_emit(input int x, input int e);
      sb_q.push_back('{out: x, err: e});
      m_h2       = m_h1;
      m_h1       = x;
      m_err      = e;
      m_last_out = x;
   endtask

   task automatic do_start(input bit with_halt);
      start = 1'b1;
      halt  = with_halt;
      din   = 9'($urandom_range(0, 511));
      model_clear();
      @(negedge clk);
      start = 1'b0;
      halt  = 1'b0;
      check("start_clears_err", int'(err), 0);
      check("start_valid_low", int'(valid), 0);
   endtask

   // Directed sample with hand-derived expectation.
   task automatic send_exp(input int y, input int x_exp, input int err_exp);
      din = 9'(y);
      model_emit(x_exp, err_exp);
      @(negedge clk);
   endtask

   // Random sample: usually a valid encoding of a random x, sometimes an arbitrary word.
   task automatic send_rand();
      int y, x, found;
      if ($urandom_range(0, 6) == 0) begin
         y     = int'($urandom_range(0, 511));
         found = -1;
         for (int c = 0; c < 16; c++)
            if (C0 * c + C1 * m_h1 + C2 * m_h2 == y) found = c;
         if (found < 0) model_emit(0, 1);
         else           model_emit(found, m_err);
      end else begin
         x = int'($urandom_range(0, 15));
         y = C0 * x + C1 * m_h1 + C2 * m_h2;
         model_emit(x, m_err);
      end
      din = 9'(y);
      @(negedge clk);
   endtask

   // Halt at edge k: valid drops at k+1, done high only after edge k+HC, idle afterwards.
   task automatic do_halt();
      halt = 1'b1;
      din  = 9'($urandom_range(0, 511));
      @(negedge clk);
      halt = 1'b0;
      check("halt_valid_low", int'(valid), 0);
      check("halt_done_low", int'(done), 0);
      check("halt_out_hold", int'(dout), m_last_out);
      for (int i = 1; i < HC; i++) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("flush_done_low", int'(done), 0);
         check("flush_valid_low", int'(valid), 0);
      end
      @(negedge clk);
      check("done_pulse", int'(done), 1);
      check("done_out_hold", int'(dout), m_last_out);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      halt  = 1'b0;
      din   = '0;
      m_last_out = 0;
      model_clear();
      repeat (3) @(negedge clk);
      check("rst_out", int'(dout), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_err", int'(err), 0);
      check("rst_done", int'(done), 0);
      rst = 1'b0;

      // Halt in IDLE is ignored.
      halt = 1'b1;
      repeat (2) @(negedge clk);
      halt = 1'b0;
      check("idle_halt_done", int'(done), 0);

      // Basic decode, then halt timing.
      do_start(1'b0);
      send_exp(3, 1, 0);
      send_exp(10, 2, 0);
      send_exp(22, 3, 0);
      send_exp(22, 0, 0);
      do_halt();

      // Maximum range.
      do_start(1'b0);
      send_exp(45, 15, 0);
      send_exp(105, 15, 0);
      send_exp(180, 15, 0);
      do_halt();

      // Error detection, stickiness, and clear on new start.
      do_start(1'b0);
      send_exp(4, 0, 1);
      send_exp(3, 1, 1);
      do_halt();
      check("err_sticky_idle", int'(err), 1);
      do_start(1'b0);
      send_exp(3, 1, 0);
      do_halt();

      // Negative residual.
      do_start(1'b0);
      send_exp(3, 1, 0);
      send_exp(0, 0, 1);
      do_halt();

      // Reset mid-run clears everything including history.
      do_start(1'b1);
      send_exp(3, 1, 0);
      send_exp(10, 2, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last_out = 0;
      model_clear();
      check("midrun_rst_out", int'(dout), 0);
      check("midrun_rst_valid", int'(valid), 0);
      check("midrun_rst_done", int'(done), 0);
      halt = 1'b1;
      din  = 9'd3;
      @(negedge clk);
      halt = 1'b0;
      check("post_rst_idle_valid", int'(valid), 0);
      do_start(1'b0);
      send_exp(3, 1, 0);

      // Reset mid-flush: no done pulse follows.
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      rst  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last_out = 0;
      model_clear();
      for (int i = 0; i < HC + 1; i++) begin
         @(negedge clk);
         check("midflush_rst_no_done", int'(done), 0);
      end
      check("midflush_rst_out", int'(dout), 0);

      // Randomized runs.
      for (int run = 0; run < 25; run++) begin
         do_start(1'($urandom_range(0, 1)));
         for (int s = 0; s < int'($urandom_range(1, 12)); s++) send_rand();
         do_halt();
      end

      @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
